// File: rtl/axis_pkg.sv
// Shared stream helpers: ceiling divide, words-per-beat sizing and the
// default wide-beat struct used by the unpacker and by bench models.
package axis_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_WPB    = 4;

    function automatic int CEIL(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Never returns less than one word per beat.
    function automatic int words_per_beat(input int bus_w, input int word_w);
        return (bus_w / word_w < 1) ? 1 : bus_w / word_w;
    endfunction

    typedef struct packed {
        logic                                 last;
        logic [DEF_WPB-1:0]                   keep;
        logic [DEF_WPB-1:0][DEF_WORD_W-1:0]   data;
    } beat_t;

endpackage

// File: rtl/axis_unpacker_if.sv
// Stream bundle carrying WORDS words per beat with per-word keep.
// The unpacker uses a WORDS-wide instance as slave and a one-word instance
// as master.
interface axis_unpacker_if #(
    parameter int WORD_W = 8,
    parameter int WORDS  = 4
);
    logic                         valid;
    logic                         ready;
    logic                         last;
    logic [WORDS-1:0]             keep;
    logic [WORDS-1:0][WORD_W-1:0] data;

    modport master (output valid, last, keep, data, input ready);
    modport slave  (input valid, last, keep, data, output ready);
endinterface

// File: rtl/axis_lsb_onehot.sv
// Lowest-set-bit priority encoder: index of the lowest set bit of i_vec and
// a flag that exactly one bit is set. Used only in sparse-keep builds.
module axis_lsb_onehot #(
    parameter int W = 4,
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_one
);
    // Scan from the top so the lowest set bit wins.
    always_comb begin
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_one = (i_vec != '0) && ((i_vec & (i_vec - W'(1))) == '0);
endmodule

// File: rtl/axis_unpacker.sv
// Wide-to-narrow AXI-Stream unpacker: one-beat holding buffer, emits kept
// words in order, one per handshake, with m_last on the final word.
// Optional feature macro: AXIS_UNPACKER_SPARSE_KEEP_EN (arbitrary keep
// patterns; otherwise keep must be a thermometer code from bit 0).
module axis_unpacker
    import axis_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int BUS_W  = 32
) (
    input  logic         clk,
    input  logic         rstn,
    axis_unpacker_if.slave  s_axis,
    axis_unpacker_if.master m_axis,
    output logic         drop_last
);
    localparam int WPB   = words_per_beat(BUS_W, WORD_W);
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    logic [WPB-1:0][WORD_W-1:0] r_data;
    logic                       r_last;
    logic                       r_valid;
    logic                       r_drop;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_one;
    logic                       w_acc;
    logic                       w_load;
    logic                       w_mfire;

    // Ready is forced low in reset; m_ready feeds s_ready combinationally so
    // a new beat can load on the same edge the last word leaves.
    assign s_axis.ready = rstn && (!r_valid || (m_axis.ready && w_one));
    assign w_acc        = s_axis.valid && s_axis.ready;
    assign w_load       = w_acc && (s_axis.keep != '0);
    assign w_mfire      = r_valid && m_axis.ready;

`ifdef AXIS_UNPACKER_SPARSE_KEEP_EN
    logic [WPB-1:0] r_rem;

    axis_lsb_onehot #(.W(WPB)) u_lsb (
        .i_vec (r_rem),
        .o_idx (w_idx),
        .o_one (w_one)
    );

    // Remaining-word mask: loaded from keep, one bit retired per word sent.
    always_ff @(posedge clk) begin
        if (!rstn)        r_rem <= '0;
        else if (w_load)  r_rem <= s_axis.keep;
        else if (w_mfire) r_rem[w_idx] <= 1'b0;
    end
`else
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_end;
    logic [IDX_W:0]   w_pop;

    // Number of kept words in the incoming beat.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WPB; i++) w_pop = w_pop + (IDX_W+1)'(s_axis.keep[i]);
    end

    assign w_idx = r_cnt;
    assign w_one = r_valid && (r_cnt == r_end);

    // Word counter walks 0..popcount-1 of the loaded thermometer keep.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_end <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
            r_end <= IDX_W'(w_pop - (IDX_W+1)'(1));
        end else if (w_mfire && !w_one) begin
            r_cnt <= r_cnt + IDX_W'(1);
        end
    end

`ifndef SYNTHESIS
    // Holes in keep are not supported without the sparse encoder.
    always @(posedge clk) begin
        if (rstn && w_acc)
            assert ((s_axis.keep & (s_axis.keep + WPB'(1))) == '0)
            else $error("axis_unpacker: non-thermometer s_keep %b", s_axis.keep);
    end
`endif
`endif

    // Holding buffer and registered drop pulse for zero-keep last beats.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_acc && (s_axis.keep == '0) && s_axis.last;
            if (w_load) begin
                r_data  <= s_axis.data;
                r_last  <= s_axis.last;
                r_valid <= 1'b1;
            end else if (w_mfire && w_one) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_axis.valid   = r_valid;
    assign m_axis.data[0] = r_data[w_idx];
    assign m_axis.keep    = '1;
    assign m_axis.last    = r_valid && r_last && w_one;
    assign drop_last      = r_drop;
endmodule

// File: tb/tb_axis_unpacker.sv
// Directed and randomized self-checking bench for axis_unpacker (8-bit
// words, 32-bit bus).
module tb_axis_unpacker;
    import axis_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic drop_last;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axis_unpacker_if #(.WORD_W(8), .WORDS(4)) s_if ();
    axis_unpacker_if #(.WORD_W(8), .WORDS(1)) m_if ();

    axis_unpacker #(.WORD_W(8), .BUS_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .drop_last (drop_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted (bounded).
    task automatic send(input logic [3:0] k, input logic [31:0] d, input logic l);
        int t;
        s_if.valid = 1'b1;
        s_if.keep  = k;
        s_if.data  = d;
        s_if.last  = l;
        t = 0;
        @(negedge clk);
        while (!s_if.ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_if.ready) chk("send_timeout", s_if.ready, 1);
        step();
        s_if.valid = 1'b0;
    endtask

    // Wait (bounded) for a word with m_ready high, check it, then consume it.
    task automatic expect_word(input string tag, input logic [7:0] d, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        while (!m_if.valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, m_if.valid, 1);
        chk({tag, "_data"}, m_if.data, d);
        chk({tag, "_last"}, m_if.last, l);
        step();
    endtask

    logic [7:0] exp_d[$];
    bit         exp_l[$];
    beat_t      beats[$];
    int         rcyc;

    initial begin
        logic [31:0] v;
        s_if.valid = 1'b0;
        s_if.keep  = '0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;

        // Reset state
        step();
        step();
        @(negedge clk);
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_m_last", m_if.last, 0);
        chk("rst_drop", drop_last, 0);
        chk("rst_s_ready", s_if.ready, 0);
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_if.ready, 1);
        chk("post_rst_m_valid", m_if.valid, 0);
        chk("post_rst_m_last", m_if.last, 0);
        chk("post_rst_drop", drop_last, 0);
        step();
        m_if.ready = 1'b1;

        // Full beat: exact cycle-by-cycle output
        v = 32'h44332211;
        send(4'b1111, v, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_valid", m_if.valid, 1);
            chk("full_data", m_if.data, v[8*i +: 8]);
            chk("full_last", m_if.last, (i == 3) ? 1 : 0);
            chk("full_s_ready", s_if.ready, (i == 3) ? 1 : 0);
            step();
        end
        @(negedge clk);
        chk("full_idle", m_if.valid, 0);
        step();

        // Partial beat
        send(4'b0011, 32'hDDCCBBAA, 1'b1);
        expect_word("part0", 8'hAA, 1'b0);
        expect_word("part1", 8'hBB, 1'b1);
        @(negedge clk);
        chk("part_idle", m_if.valid, 0);
        step();
`ifdef AXIS_UNPACKER_SPARSE_KEEP_EN
        send(4'b1010, 32'hDDCCBBAA, 1'b1);
        expect_word("sparse0", 8'hBB, 1'b0);
        expect_word("sparse1", 8'hDD, 1'b1);
`endif

        // Backpressure mid-beat
        send(4'b1111, 32'h88776655, 1'b1);
        @(negedge clk);
        chk("bp_w0", m_if.data, 8'h55);
        step();
        m_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", m_if.valid, 1);
            chk("bp_hold_data", m_if.data, 8'h66);
            chk("bp_hold_last", m_if.last, 0);
            chk("bp_hold_s_ready", s_if.ready, 0);
            step();
        end
        m_if.ready = 1'b1;
        expect_word("bp_w1", 8'h66, 1'b0);
        expect_word("bp_w2", 8'h77, 1'b0);
        expect_word("bp_w3", 8'h88, 1'b1);
        @(negedge clk);
        chk("bp_idle", m_if.valid, 0);
        step();

        // Zero-keep last beat
        s_if.valid = 1'b1;
        s_if.keep  = 4'b0000;
        s_if.data  = 32'hCAFEF00D;
        s_if.last  = 1'b1;
        @(negedge clk);
        chk("zk_s_ready_pre", s_if.ready, 1);
        step();
        s_if.valid = 1'b0;
        @(negedge clk);
        chk("zk_drop_hi", drop_last, 1);
        chk("zk_m_valid", m_if.valid, 0);
        chk("zk_s_ready", s_if.ready, 1);
        step();
        @(negedge clk);
        chk("zk_drop_lo", drop_last, 0);
        chk("zk_m_valid2", m_if.valid, 0);
        step();

        // Reset after 2 of 4 words
        send(4'b1111, 32'h04030201, 1'b1);
        expect_word("mr_w0", 8'h01, 1'b0);
        expect_word("mr_w1", 8'h02, 1'b0);
        rstn = 1'b0;
        step();
        @(negedge clk);
        chk("mr_m_valid", m_if.valid, 0);
        chk("mr_m_last", m_if.last, 0);
        chk("mr_s_ready", s_if.ready, 0);
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("mr_rel_m_valid", m_if.valid, 0);
        chk("mr_rel_s_ready", s_if.ready, 1);
        step();
        send(4'b1111, 32'hDDCCBBAA, 1'b1);
        expect_word("mr_n0", 8'hAA, 1'b0);
        expect_word("mr_n1", 8'hBB, 1'b0);
        expect_word("mr_n2", 8'hCC, 1'b0);
        expect_word("mr_n3", 8'hDD, 1'b1);

        // Random packets: build reference stream and beat list
        m_if.ready = 1'b0;
        for (int p = 0; p < 100; p++) begin
            int n;
            n = $urandom_range(100, 1);
            for (int w = 0; w < n; w++) begin
                exp_d.push_back(8'($urandom_range(255, 0)));
                exp_l.push_back(w == n - 1);
            end
            for (int off = 0; off < n; off += 4) begin
                beat_t b;
                int    k;
                int    base;
                base   = exp_d.size() - n + off;
                k      = (n - off < 4) ? n - off : 4;
                b      = '0;
                b.keep = 4'((1 << k) - 1);
                for (int i = 0; i < k; i++) b.data[i] = exp_d[base + i];
                b.last = (off + k == n);
                beats.push_back(b);
            end
        end

        rcyc = 0;
        fork
            begin : producer
                for (int j = 0; j < beats.size(); j++) begin
                    bit sent;
                    sent = 1'b0;
                    while (!sent && rcyc < 90000) begin
                        if (!s_if.valid && $urandom_range(99, 0) < 20) begin
                            s_if.valid = 1'b1;
                            s_if.keep  = beats[j].keep;
                            s_if.data  = beats[j].data;
                            s_if.last  = beats[j].last;
                        end
                        @(negedge clk);
                        if (s_if.valid && s_if.ready) sent = 1'b1;
                        step();
                        if (sent) s_if.valid = 1'b0;
                    end
                    if (!sent) begin
                        chk("rand_send_timeout", sent, 1);
                        break;
                    end
                end
                s_if.valid = 1'b0;
            end
            begin : consumer
                int got;
                int lasts;
                got   = 0;
                lasts = 0;
                while (got < exp_d.size() && rcyc < 90000) begin
                    m_if.ready = ($urandom_range(99, 0) < 10);
                    @(negedge clk);
                    if (m_if.valid && m_if.ready) begin
                        chk("rand_data", m_if.data, exp_d[got]);
                        chk("rand_last", m_if.last, exp_l[got]);
                        if (m_if.last) lasts++;
                        got++;
                    end
                    step();
                    rcyc++;
                end
                m_if.ready = 1'b0;
                chk("rand_word_count", got, exp_d.size());
                chk("rand_last_count", lasts, 100);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_unpacker.md
# axis_unpacker

Synthesizable AXI-Stream width down-converter: accepts packets on a wide slave bus carrying `WORDS_PER_BEAT` words per beat with per-word `keep`, and re-emits them on a master bus one word per beat, preserving word order and packet boundaries. It is the receive-side counterpart of the multi-word beat packing used by our stream sources, and sits between a wide producer (DMA/array output) and narrow word consumers.

## Interface
- `WORD_W`, 8: width of one word in bits.
- `BUS_W`, 32: slave data width in bits; must be an integer multiple of `WORD_W`.
- `WORDS_PER_BEAT` (localparam), `BUS_W/WORD_W`: number of words per slave beat; must be at least 1.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `s_valid` in 1: slave beat valid.
- `s_ready` out 1: slave beat ready.
- `s_last` in 1: final beat of the packet.
- `s_keep` in `WORDS_PER_BEAT`: per-word valid; bit i qualifies `s_data[i]`.
- `s_data` in `WORDS_PER_BEAT` x `WORD_W`: packed words; word 0 is first in stream order.
- `m_valid` out 1: word valid.
- `m_ready` in 1: word accepted.
- `m_last` out 1: final word of the packet.
- `m_data` out `WORD_W`: current word.
- `drop_last` out 1: one-cycle pulse when an all-zero-keep beat carrying `s_last` is discarded.

## Operation
- Uses a one-beat holding buffer with these fields: `buf_data`, `buf_last`, `rem` (remaining keep mask), and `buf_valid`.
- Accept condition: `s_valid && s_ready` at a rising edge.
- On accept with `s_keep != 0`:
  - load the buffer;
  - set `rem = s_keep`;
  - set `buf_valid = 1`.
- On accept with `s_keep == 0`:
  - the beat is discarded and the buffer is not loaded;
  - if `s_last` is set, `drop_last` pulses in the next cycle;
  - the packet's last flag is lost; this is reported, not recovered.
- Output word selection:
  - `idx` = lowest set bit of `rem`;
  - `m_data = buf_data[idx]`;
  - `m_valid = buf_valid`.
- `m_last = buf_last && (rem has exactly one bit set)`.
- On `m_valid && m_ready`:
  - clear `rem[idx]`;
  - if that was the last set bit, `buf_valid` clears, unless a new beat is accepted in the same edge.
- `s_ready = !buf_valid || (m_ready && rem has exactly one bit set)`.
  - This gives full throughput with no bubble between beats.
  - There is a combinational path from `m_ready` to `s_ready`; this is intended.
- Simultaneous last-word handoff and new-beat accept: the new beat loads, and `buf_valid` stays 1.
- While `m_valid` is high and `m_ready` is low, `m_data`, `m_last` and `m_valid` are held stable.

## Timing
- Latency: a beat accepted at edge N presents its first word from cycle N+1 (after edge N).
- A beat with k kept words occupies k output handshakes. With `m_ready` held high, the following beat's first word appears on the edge after the k-th word.
- While `rstn` is low, and on the first cycle after it rises:
  - `m_valid=0`, `m_last=0`, `drop_last=0`;
  - `s_ready=0` during reset, `s_ready=1` from the first cycle with `rstn=1` (buffer empty);
  - `m_data` is don't-care.
- Reset mid-packet: buffer contents are discarded. No remaining words are emitted and no `m_last` is produced for that packet.
- `drop_last` is registered: exactly one cycle high per discarded last beat.

## Configuration
- `AXIS_UNPACKER_SPARSE_KEEP_EN` defined:
  - arbitrary `s_keep` patterns are legal;
  - holes are skipped via the lowest-set-bit priority encoder.
- `AXIS_UNPACKER_SPARSE_KEEP_EN` undefined:
  - `s_keep` must be contiguous from bit 0 (thermometer);
  - `idx` is a plain word counter, 0 up to popcount−1;
  - `m_last` asserts when the counter reaches the popcount−1 of the loaded keep;
  - sparse patterns are undefined behaviour;
  - a simulation-only assertion flags non-thermometer `s_keep` on accept.

## Structure
- Shared package `axis_pkg`:
  - `CEIL` helper;
  - `words_per_beat(BUS_W, WORD_W)` function;
  - typedef of the keep/data beat struct used by both this block and the bench models.
- Sub-module `axis_lsb_onehot`: combinational lowest-set-bit priority encoder (index output plus "exactly one bit" flag). It is instantiated only when `AXIS_UNPACKER_SPARSE_KEEP_EN` is defined.

## Test plan
All scenarios use `WORD_W=8`, `BUS_W=32`.
- Full beat: `s_keep=4'b1111`, `s_data=32'h44332211`, `s_last=1`, `m_ready=1` → `m_data` 11,22,33,44 on consecutive cycles; `m_last` only with 44; `s_ready=1` in the cycle 44 is presented.
- Partial beat: `s_keep=4'b0011`, data `32'hDDCCBBAA`, last → AA, BB(`m_last`). With the macro, `s_keep=4'b1010` → BB, DD(`m_last`).
- Backpressure: `m_ready=0` for 5 cycles mid-beat → `m_data`/`m_last` stable, `s_ready=0`; resumes with no word lost or duplicated.
- Zero-keep last beat: `s_keep=0`, `s_last=1` → no `m_valid`; `drop_last` is high exactly one cycle; `s_ready` stays 1.
- Reset after 2 of 4 words → `m_valid=0` the next cycle; after release, the next packet starts cleanly at word 0.
- Random: 100 packets of 1–100 words, valid probability 20%, ready probability 10% → output stream equals the input words in order, with `m_last` count equal to 100.
